button_conditioner: RTL and testbench



---
 rtl/button_conditioner.sv | 166 ++++++++++++++++
 tb/tb_button_conditioner.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
`timescale 1ns / 1ps
// Synchronises, debounces and conditions the inc/mode/sel push-buttons for the button PIO inputs.
// Define BTN_AUTOREPEAT_EN to add hold-to-repeat on the inc channel.
module button_conditioner #(
  parameter int unsigned DB_CYCLES         = 1000000,
  parameter int unsigned RPT_DELAY_CYCLES  = 25000000,
  parameter int unsigned RPT_PERIOD_CYCLES = 5000000,
  parameter int unsigned RPT_GAP_CYCLES    = 50000,
  parameter int unsigned KEY_ACTIVE_LOW    = 1
) (
  input  logic       clk_clk,
  input  logic       reset_reset,
  input  logic       key_inc,
  input  logic       key_mode,
  input  logic       key_sel,
  output logic       btinc_export,
  output logic       btmode_export,
  output logic       btsel_export,
  output logic [2:0] press_pulse
);

  localparam int unsigned CntW = $clog2(DB_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(DB_CYCLES - 1);
  localparam logic [2:0] RelLvl = (KEY_ACTIVE_LOW != 0) ? 3'b111 : 3'b000;

  logic [2:0]      sync1_q, sync2_q;
  logic [2:0]      pressed;
  logic [2:0]      stable_q, stable_d;
  logic [CntW-1:0] cnt_q [3];
  logic [CntW-1:0] cnt_d [3];
  logic [2:0]      level, lvl_dly_q, pulse_q, pulse_d;

  // Bit order throughout is {sel, mode, inc}.
  assign pressed = sync2_q ^ RelLvl;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      stable_d[i] = stable_q[i];
      cnt_d[i]    = '0;
      if (pressed[i] != stable_q[i]) begin
        if (cnt_q[i] == CntLast) begin
          stable_d[i] = pressed[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      sync1_q  <= RelLvl;
      sync2_q  <= RelLvl;
      stable_q <= '0;
      cnt_q    <= '{default: '0};
    end else begin
      sync1_q  <= {key_sel, key_mode, key_inc};
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int unsigned RptMax = (RPT_DELAY_CYCLES > RPT_PERIOD_CYCLES) ?
                                   RPT_DELAY_CYCLES : RPT_PERIOD_CYCLES;
  localparam int unsigned TmrW = (RptMax > 1) ? $clog2(RptMax) : 1;
  localparam logic [TmrW-1:0] DelayLast = TmrW'(RPT_DELAY_CYCLES - 1);
  localparam logic [TmrW-1:0] GapLast   = TmrW'(RPT_GAP_CYCLES - 1);
  localparam logic [TmrW-1:0] OnLast    = TmrW'(RPT_PERIOD_CYCLES - RPT_GAP_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StHold, StGap, StOn} rpt_st_e;

  rpt_st_e         st_q, st_d;
  logic [TmrW-1:0] tmr_q, tmr_d;
  logic            inc_q, inc_d;
  logic            inc_rise, inc_fall;

  // Edges are taken from the debounce next-state so the FSM reacts in the same cycle.
  assign inc_rise = stable_d[0] & ~stable_q[0];
  assign inc_fall = ~stable_d[0] & stable_q[0];

  always_comb begin
    st_d  = st_q;
    tmr_d = tmr_q + TmrW'(1);
    inc_d = inc_q;
    if (inc_fall) begin
      st_d  = StIdle;
      tmr_d = '0;
      inc_d = 1'b0;
    end else begin
      unique case (st_q)
        StIdle: begin
          tmr_d = '0;
          if (inc_rise) begin
            st_d  = StHold;
            inc_d = 1'b1;
          end
        end
        StHold: begin
          if (tmr_q == DelayLast) begin
            st_d  = StGap;
            tmr_d = '0;
            inc_d = 1'b0;
          end
        end
        StGap: begin
          if (tmr_q == GapLast) begin
            st_d  = StOn;
            tmr_d = '0;
            inc_d = 1'b1;
          end
        end
        StOn: begin
          if (tmr_q == OnLast) begin
            st_d  = StGap;
            tmr_d = '0;
            inc_d = 1'b0;
          end
        end
        default: begin
          st_d  = StIdle;
          tmr_d = '0;
          inc_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      st_q  <= StIdle;
      tmr_q <= '0;
      inc_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      tmr_q <= tmr_d;
      inc_q <= inc_d;
    end
  end

  assign btinc_export = inc_q;
`else
  logic unused_rpt;
  assign unused_rpt   = ^{RPT_DELAY_CYCLES, RPT_PERIOD_CYCLES, RPT_GAP_CYCLES};
  assign btinc_export = stable_q[0];
`endif

  assign btmode_export = stable_q[1];
  assign btsel_export  = stable_q[2];
  assign level         = {btsel_export, btmode_export, btinc_export};
  assign pulse_d       = level & ~lvl_dly_q;

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      lvl_dly_q <= '0;
      pulse_q   <= '0;
    end else begin
      lvl_dly_q <= level;
      pulse_q   <= pulse_d;
    end
  end

  assign press_pulse = pulse_q;

endmodule

// File: tb/tb_button_conditioner.sv
`timescale 1ns / 1ps
// Scoreboard bench for button_conditioner: stimulus queues expected output changes with their
// cycle, a negedge monitor pops and compares on every change of the output vector.
module tb_button_conditioner;

  logic       clk_clk     = 1'b0;
  logic       reset_reset = 1'b1;
  logic       key_inc     = 1'b1;
  logic       key_mode    = 1'b1;
  logic       key_sel     = 1'b1;
  logic       btinc_export, btmode_export, btsel_export;
  logic [2:0] press_pulse;

  // Vector layout: {press_pulse[2:0], btsel, btmode, btinc}
  typedef struct {
    int         cyc;
    logic [5:0] vec;
  } evt_t;

  evt_t       exp_q[$];
  evt_t       mon_e;
  int         cyc      = 0;
  int         n_checks = 0;
  int         n_fail   = 0;
  int         t;
  logic       mon_en   = 1'b0;
  logic [5:0] mon_last = '0;
  logic [5:0] mon_cur;

  button_conditioner #(
    .DB_CYCLES        (8),
    .RPT_DELAY_CYCLES (40),
    .RPT_PERIOD_CYCLES(20),
    .RPT_GAP_CYCLES   (4),
    .KEY_ACTIVE_LOW   (1)
  ) dut (
    .clk_clk      (clk_clk),
    .reset_reset  (reset_reset),
    .key_inc      (key_inc),
    .key_mode     (key_mode),
    .key_sel      (key_sel),
    .btinc_export (btinc_export),
    .btmode_export(btmode_export),
    .btsel_export (btsel_export),
    .press_pulse  (press_pulse)
  );

  always #5 clk_clk = ~clk_clk;

  always @(posedge clk_clk) cyc <= cyc + 1;

  always @(negedge clk_clk) begin
    if (mon_en) begin
      mon_cur = {press_pulse, btsel_export, btmode_export, btinc_export};
      if (mon_cur !== mon_last) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_change: cycle %0d got %b, required no change from %b",
                   cyc, mon_cur, mon_last);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.cyc != cyc || mon_e.vec !== mon_cur) begin
            n_fail++;
            $display("FAIL output_event: got %b at cycle %0d, required %b at cycle %0d",
                     mon_cur, cyc, mon_e.vec, mon_e.cyc);
          end
        end
      end
      mon_last = mon_cur;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk_clk);
      #1;
    end
  endtask

  task automatic expect_at(input int when, input logic [5:0] v);
    evt_t e;
    e.cyc = when;
    e.vec = v;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b, required %b", name, act, req);
    end
  endtask

  task automatic drain(input string name);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d expected events still pending, required 0", name,
               exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    step(3);
    check("reset_levels", {3'b000, btsel_export, btmode_export, btinc_export}, 6'b0);
    check("reset_pulse", {3'b000, press_pulse}, 6'b0);
    reset_reset = 1'b0;
    mon_en      = 1'b1;
    step(3);

    // 1: clean mode press and release
    t = cyc;
    key_mode = 1'b0;
    expect_at(t + 10, 6'b000_010);
    expect_at(t + 11, 6'b010_010);
    expect_at(t + 12, 6'b000_010);
    step(20);
    t = cyc;
    key_mode = 1'b1;
    expect_at(t + 10, 6'b000_000);
    step(15);
    drain("mode_clean");

    // 2: bouncing sel, only the final edge counts
    key_sel = 1'b0; step(5);
    key_sel = 1'b1; step(2);
    key_sel = 1'b0; step(5);
    key_sel = 1'b1; step(2);
    t = cyc;
    key_sel = 1'b0;
    expect_at(t + 10, 6'b000_100);
    expect_at(t + 11, 6'b100_100);
    expect_at(t + 12, 6'b000_100);
    step(20);
    t = cyc;
    key_sel = 1'b1;
    expect_at(t + 10, 6'b000_000);
    step(15);
    drain("sel_bounce");

    // 3: inc held 120 cycles
    t = cyc;
    key_inc = 1'b0;
    expect_at(t + 10, 6'b000_001);
    expect_at(t + 11, 6'b001_001);
    expect_at(t + 12, 6'b000_001);
`ifdef BTN_AUTOREPEAT_EN
    for (int k = 0; k < 4; k++) begin
      expect_at(t + 50 + 20 * k, 6'b000_000);
      expect_at(t + 54 + 20 * k, 6'b000_001);
      expect_at(t + 55 + 20 * k, 6'b001_001);
      expect_at(t + 56 + 20 * k, 6'b000_001);
    end
`endif
    expect_at(t + 130, 6'b000_000);
    step(120);
    key_inc = 1'b1;
    step(20);
    drain("inc_hold");

    // 4: inc released so the debounced fall lands in the first gap
    t = cyc;
    key_inc = 1'b0;
    expect_at(t + 10, 6'b000_001);
    expect_at(t + 11, 6'b001_001);
    expect_at(t + 12, 6'b000_001);
`ifdef BTN_AUTOREPEAT_EN
    expect_at(t + 50, 6'b000_000);
`else
    expect_at(t + 51, 6'b000_000);
`endif
    step(41);
    key_inc = 1'b1;
    step(45);
    drain("inc_gap_release");

    // 5: all three keys in the same cycle
    t = cyc;
    {key_sel, key_mode, key_inc} = 3'b000;
    expect_at(t + 10, 6'b000_111);
    expect_at(t + 11, 6'b111_111);
    expect_at(t + 12, 6'b000_111);
    step(20);
    t = cyc;
    {key_sel, key_mode, key_inc} = 3'b111;
    expect_at(t + 10, 6'b000_000);
    step(15);
    drain("all_keys");

    // 6: reset while inc is held and asserted
    t = cyc;
    key_inc = 1'b0;
    expect_at(t + 10, 6'b000_001);
    expect_at(t + 11, 6'b001_001);
    expect_at(t + 12, 6'b000_001);
    step(20);
    reset_reset = 1'b1;
    #1;
    check("reset_async", {3'b000, btsel_export, btmode_export, btinc_export}, 6'b0);
    expect_at(cyc + 1, 6'b000_000);
    step(3);
    reset_reset = 1'b0;
    t = cyc;
    expect_at(t + 10, 6'b000_001);
    expect_at(t + 11, 6'b001_001);
    expect_at(t + 12, 6'b000_001);
    step(20);
    t = cyc;
    key_inc = 1'b1;
    expect_at(t + 10, 6'b000_000);
    step(15);
    drain("reset_midpress");

    step(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
